// File: rtl/risc8_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | risc8_pkg: instruction-class / ALU-op codes and two-word masks      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package risc8_pkg;

    typedef enum logic [4:0] {
        IS_ALU = 5'd0, IS_MULU, IS_MULS, IS_LDS, IS_STS, IS_JMP, IS_CALL,
        IS_RJMP, IS_RCALL, IS_RET, IS_BRANCH, IS_SKIP, IS_LD, IS_ST,
        IS_PUSH, IS_POP, IS_IN, IS_OUT, IS_MOVW, IS_NOP, IS_BLD_OR_BST
    } instr_class_t;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0, OP_ADC, OP_SUB, OP_SBC, OP_AND, OP_OR, OP_EOR, OP_MOV,
        OP_COM, OP_NEG, OP_INC, OP_DEC, OP_LSR, OP_ROR, OP_ASR, OP_SWAP
    } alu_op_t;

    localparam logic [15:0] LDS_STS_MASK   = 16'hFC0F;
    localparam logic [15:0] LDS_STS_MATCH  = 16'h9000;
    localparam logic [15:0] JMP_CALL_MASK  = 16'hFE0C;
    localparam logic [15:0] JMP_CALL_MATCH = 16'h940C;

    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & LDS_STS_MASK) == LDS_STS_MATCH) ||
               ((w & JMP_CALL_MASK) == JMP_CALL_MATCH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/risc8_word_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | risc8_word_fifo: circular word queue, 2-entry peek, 0/1/2 pop       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module risc8_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_clear,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic [1:0]               i_pop_n,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic [WIDTH-1:0]         o_head0,
    output logic [WIDTH-1:0]         o_head1
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;

    // No pop-to-push bypass: a full queue refuses even while popping.
    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign w_push  = i_push && !o_full && !i_clear;
    assign o_count = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr <= r_rd_ptr + PTR_W'(i_pop_n);
            r_count  <= r_count + CNT_W'(w_push) - CNT_W'(i_pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer arithmetic wraps naturally, so a split two-word head peeks correctly.
    assign o_head0 = r_mem[r_rd_ptr];
    assign o_head1 = r_mem[r_rd_ptr + PTR_W'(1)];

endmodule
`default_nettype wire

// File: rtl/risc8_decode_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | risc8_decode_queue: fetch word queue with instruction pre-decode    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module risc8_decode_queue
    import risc8_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int PC_W       = 16,
    parameter int ENABLE_MUL = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            fetch_valid,
    output logic            fetch_ready,
    input  logic [15:0]     fetch_word,
    input  logic [PC_W-1:0] fetch_pc,
    input  logic            flush,
    input  logic            skip,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [15:0]     dec_opcode,
    output logic [15:0]     dec_operand,
    output logic [PC_W-1:0] dec_pc,
    output logic            dec_len2,
    output logic [4:0]      dec_instr,
    output logic [3:0]      dec_alu_op,
    output logic            dec_alu_rdi,
    output logic            dec_alu_store,
    output logic            dec_alu_carry,
    output logic            dec_illegal
);
    localparam int WIDTH = 16 + PC_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic [WIDTH-1:0] w_head0, w_head1;
    logic [15:0]      w_word0, w_word1;
    logic             w_len2, w_complete, w_accept, w_skip_drop;
    logic [1:0]       w_pop_n;
    logic             w_unused_pc1;
    logic             r_skip_pend;

    instr_class_t     w_instr;
    alu_op_t          w_alu_op;
    logic             w_rdi, w_store, w_carry, w_mul, w_illegal;

    risc8_word_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_clear (flush),
        .i_push  (fetch_valid),
        .i_data  ({fetch_word, fetch_pc}),
        .i_pop_n (w_pop_n),
        .o_count (w_count),
        .o_full  (w_full),
        .o_head0 (w_head0),
        .o_head1 (w_head1)
    );

    assign w_word0      = w_head0[WIDTH-1:PC_W];
    assign w_word1      = w_head1[WIDTH-1:PC_W];
    assign w_unused_pc1 = ^w_head1[PC_W-1:0];
    assign w_len2       = is_two_word(w_word0);
    assign w_complete   = (w_count >= CNT_W'(1)) && (!w_len2 || (w_count >= CNT_W'(2)));
    assign w_accept     = dec_valid && dec_ready;
    assign w_skip_drop  = r_skip_pend && w_complete;
    assign w_pop_n      = (w_accept || w_skip_drop) ? (w_len2 ? 2'd2 : 2'd1) : 2'd0;

    // A skip raised alongside an accept targets the instruction after the head.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_skip_pend <= 1'b0;
        end else if (flush) begin
            r_skip_pend <= 1'b0;
        end else if (skip) begin
            r_skip_pend <= 1'b1;
        end else if (w_skip_drop) begin
            r_skip_pend <= 1'b0;
        end
    end

    always_comb begin
        w_instr  = IS_ALU;
        w_alu_op = OP_ADD;
        w_rdi    = 1'b0;
        w_store  = 1'b0;
        w_carry  = 1'b0;
        w_mul    = 1'b0;
        casez (w_word0)
            16'b0000_0000_0000_0000: w_instr = IS_NOP;
            16'b0000_0001_????_????: w_instr = IS_MOVW;
            16'b0000_001?_????_????: begin w_instr = IS_MULS; w_store = 1'b1; w_mul = 1'b1; end
            16'b0000_01??_????_????: begin w_alu_op = OP_SBC; w_carry = 1'b1; end
            16'b0000_10??_????_????: begin w_alu_op = OP_SBC; w_carry = 1'b1; w_store = 1'b1; end
            16'b0000_11??_????_????: begin w_alu_op = OP_ADD; w_store = 1'b1; end
            16'b0001_00??_????_????: w_instr = IS_SKIP;
            16'b0001_01??_????_????: w_alu_op = OP_SUB;
            16'b0001_10??_????_????: begin w_alu_op = OP_SUB; w_store = 1'b1; end
            16'b0001_11??_????_????: begin w_alu_op = OP_ADC; w_carry = 1'b1; w_store = 1'b1; end
            16'b0010_00??_????_????: begin w_alu_op = OP_AND; w_store = 1'b1; end
            16'b0010_01??_????_????: begin w_alu_op = OP_EOR; w_store = 1'b1; end
            16'b0010_10??_????_????: begin w_alu_op = OP_OR;  w_store = 1'b1; end
            16'b0010_11??_????_????: begin w_alu_op = OP_MOV; w_store = 1'b1; end
            16'b0011_????_????_????: begin w_alu_op = OP_SUB; w_rdi = 1'b1; end
            16'b0100_????_????_????: begin w_alu_op = OP_SBC; w_rdi = 1'b1; w_carry = 1'b1; w_store = 1'b1; end
            16'b0101_????_????_????: begin w_alu_op = OP_SUB; w_rdi = 1'b1; w_store = 1'b1; end
            16'b0110_????_????_????: begin w_alu_op = OP_OR;  w_rdi = 1'b1; w_store = 1'b1; end
            16'b0111_????_????_????: begin w_alu_op = OP_AND; w_rdi = 1'b1; w_store = 1'b1; end
            16'b10?0_??0?_????_????: w_instr = IS_LD;
            16'b10?0_??1?_????_????: w_instr = IS_ST;
            16'b1001_000?_????_0000: w_instr = IS_LDS;
            16'b1001_001?_????_0000: w_instr = IS_STS;
            16'b1001_000?_????_1111: w_instr = IS_POP;
            16'b1001_001?_????_1111: w_instr = IS_PUSH;
            16'b1001_000?_????_????: w_instr = IS_LD;
            16'b1001_001?_????_????: w_instr = IS_ST;
            16'b1001_010?_????_0000: begin w_alu_op = OP_COM;  w_store = 1'b1; end
            16'b1001_010?_????_0001: begin w_alu_op = OP_NEG;  w_store = 1'b1; end
            16'b1001_010?_????_0010: begin w_alu_op = OP_SWAP; w_store = 1'b1; end
            16'b1001_010?_????_0011: begin w_alu_op = OP_INC;  w_store = 1'b1; end
            16'b1001_010?_????_0101: begin w_alu_op = OP_ASR;  w_store = 1'b1; end
            16'b1001_010?_????_0110: begin w_alu_op = OP_LSR;  w_store = 1'b1; end
            16'b1001_010?_????_0111: begin w_alu_op = OP_ROR;  w_store = 1'b1; end
            16'b1001_010?_????_1010: begin w_alu_op = OP_DEC;  w_store = 1'b1; end
            16'b1001_0101_000?_1000: w_instr = IS_RET;
            16'b1001_010?_????_110?: w_instr = IS_JMP;
            16'b1001_010?_????_111?: w_instr = IS_CALL;
            16'b1001_10?1_????_????: w_instr = IS_SKIP;
            16'b1001_11??_????_????: begin w_instr = IS_MULU; w_store = 1'b1; w_mul = 1'b1; end
            16'b1011_0???_????_????: w_instr = IS_IN;
            16'b1011_1???_????_????: w_instr = IS_OUT;
            16'b1100_????_????_????: w_instr = IS_RJMP;
            16'b1101_????_????_????: w_instr = IS_RCALL;
            16'b1110_????_????_????: begin w_alu_op = OP_MOV; w_rdi = 1'b1; w_store = 1'b1; end
            16'b1111_0???_????_????: w_instr = IS_BRANCH;
            16'b1111_10??_????_????: w_instr = IS_BLD_OR_BST;
            16'b1111_11??_????_????: w_instr = IS_SKIP;
            default: ;
        endcase
        // Unreset storage may hold a MUL word, so only flag it for a live head.
        w_illegal = w_mul && (ENABLE_MUL == 0) && (w_count != '0);
        if (w_mul && (ENABLE_MUL == 0)) begin
            w_instr = IS_ALU;
            w_store = 1'b0;
        end
    end

    assign fetch_ready   = !w_full;
    assign dec_valid     = w_complete && !r_skip_pend;
    assign dec_opcode    = w_word0;
    assign dec_operand   = w_len2 ? w_word1 : 16'h0000;
    assign dec_pc        = w_head0[PC_W-1:0];
    assign dec_len2      = w_len2;
    assign dec_instr     = w_instr;
    assign dec_alu_op    = w_alu_op;
    assign dec_alu_rdi   = w_rdi;
    assign dec_alu_store = w_store;
    assign dec_alu_carry = w_carry;
    assign dec_illegal   = w_illegal;

endmodule
`default_nettype wire

// File: doc/risc8_decode_queue.md
RISC8_DECODE_QUEUE -- requirements
Module: risc8_decode_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, instruction-word queue depth (power of 2, >=2).
REQ-002 SHALL provide parameter PC_W, default 16, program-counter width in words.
REQ-003 SHALL provide parameter ENABLE_MUL, default 1; 0 marks MUL-class opcodes illegal.
REQ-004 SHALL have ports, in this order:
- clk  input  1  sole clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- fetch_valid  input  1  fetch word offered.
- fetch_ready  output  1  queue can accept a word.
- fetch_word  input  16  program word.
- fetch_pc  input  PC_W  word address of fetch_word.
- flush  input  1  branch taken; discard queue.
- skip  input  1  discard the next complete instruction (CPSE/SBRx/SBIx taken).
- dec_valid  output  1  complete instruction at head.
- dec_ready  input  1  consumer takes head instruction.
- dec_opcode  output  16  first word.
- dec_operand  output  16  second word; 0 for one-word instructions.
- dec_pc  output  PC_W  address of first word.
- dec_len2  output  1  instruction is two words.
- dec_instr  output  5  macro-instruction class.
- dec_alu_op  output  4  ALU operation.
- dec_alu_rdi  output  1  immediate-form register (r16-r31).
- dec_alu_store  output  1  ALU result written back.
- dec_alu_carry  output  1  ALU uses carry in.
- dec_illegal  output  1  opcode disabled by parameter.

Function
REQ-005 SHALL store {fetch_word, fetch_pc} in a circular queue on each cycle with fetch_valid && fetch_ready.
REQ-006 SHALL drive fetch_ready = (count < DEPTH); no same-cycle pop-to-push bypass when full.
REQ-007 SHALL classify LDS, STS (1001_00xd_dddd_0000), JMP (1001_010k_kkkk_110k) and CALL (1001_010k_kkkk_111k) as two-word; all others one-word.
REQ-008 SHALL assert dec_valid when count>=1 and head is one-word, or count>=2 and head is two-word, and skip_pend=0.
REQ-009 SHALL present dec_* combinationally from queue head; a word accepted in cycle N is visible on dec_* in N+1 at earliest.
REQ-010 SHALL pop 1 or 2 words (per dec_len2) on dec_valid && dec_ready; push and pop in the same cycle SHALL both take effect.
REQ-011 SHALL decode dec_instr/dec_alu_* with the team's instruction-class and ALU-op encoding (IS_ALU..IS_BLD_OR_BST, OP_*), defaults IS_ALU/0.
REQ-012 SHALL, when ENABLE_MUL=0, force dec_illegal=1 and dec_instr=IS_ALU with dec_alu_store=0 for MUL-class opcodes; dec_illegal=0 otherwise.
REQ-013 SHALL set skip_pend on skip; while skip_pend, dec_valid=0 and the next complete instruction (1 or 2 words) SHALL be popped silently, then skip_pend clears.
REQ-014 SHALL, on skip asserted with dec_valid && dec_ready in the same cycle, pop the current head and apply the skip to the following instruction.
REQ-015 SHALL, on flush, clear count, pointers and skip_pend next edge; a fetch word accepted or skip asserted in the flush cycle SHALL be discarded; flush has priority over all other events.
REQ-016 SHALL wrap read/write pointers modulo DEPTH; a two-word head split across the wrap boundary SHALL decode correctly.
REQ-017 SHALL hold dec_* stable while dec_valid && !dec_ready.

Reset
REQ-018 SHALL on reset_n=0 asynchronously clear count, pointers, skip_pend; fetch_ready=1, dec_valid=0, dec_illegal=0 during and after reset.
REQ-019 SHALL need no reset on queue storage; dec_* data outputs are don't-care while dec_valid=0.

Structure
REQ-020 SHALL take instruction-class codes, ALU-op codes and two-word opcode masks from shared package risc8_pkg.
REQ-021 SHALL place storage and pointers in sub-module risc8_word_fifo (parameter DEPTH, width 16+PC_W, 2-word peek, 1/2-word pop).

Verification
REQ-022 SHALL cover: push 0x0C01 (ADD) at pc 0x10 -> next cycle dec_valid=1, dec_instr=IS_ALU, dec_alu_op=OP_ADD, dec_alu_store=1, dec_len2=0.
REQ-023 SHALL cover: push 0x940C then 0x1234 (JMP) -> dec_valid=0 after first word only; after second, dec_len2=1, dec_operand=0x1234, dec_instr=IS_JMP; pop removes both.
REQ-024 SHALL cover: skip pulse then push 0x9100,0x0060 (LDS),0xE0FF (LDI) -> LDS never presented; LDI presented with dec_alu_rdi=1.
REQ-025 SHALL cover: DEPTH=4 full, dec_ready=0 -> fetch_ready=0; flush with fetch_valid=1 -> next cycle count=0, dec_valid=0, fetch_ready=1.
REQ-026 SHALL cover: ENABLE_MUL=0, push 0x9C12 -> dec_illegal=1, dec_alu_store=0; ENABLE_MUL=1 -> dec_instr=IS_MULU, dec_illegal=0.
REQ-027 SHALL cover: reset_n low mid-stream with 3 words queued -> immediate dec_valid=0, fetch_ready=1; two-word instruction straddling pointer wrap decodes correctly after refill.
